// File: rtl/square_sum_cal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : square_sum_cal_pkg                                               |
// | Brief    : Shared widths, iteration count and FSM encoding for the I/Q      |
// |            power path (square-sum and square-root stages).                  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package square_sum_cal_pkg;

    localparam int C_IN_WIDTH   = 71;
    localparam int C_OUT_WIDTH  = 2 * C_IN_WIDTH;
    localparam int C_ITERATIONS = C_IN_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_squarer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_squarer                                                   |
// | Brief    : LSB-first shift-add squarer of an unsigned magnitude, one        |
// |            iteration per step strobe, loaded by a start strobe.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_squarer
    import square_sum_cal_pkg::*;
#(
    parameter int IN_WIDTH  = C_IN_WIDTH,
    parameter int OUT_WIDTH = C_OUT_WIDTH
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step,
    input  logic [IN_WIDTH-1:0]  magnitude,
    output logic [OUT_WIDTH-1:0] square
);

    logic [OUT_WIDTH-1:0] r_multiplicand;
    logic [IN_WIDTH-1:0]  r_multiplier;
    logic [OUT_WIDTH-1:0] r_accumulator;

    // The multiplicand doubles while the multiplier drains, so after IN_WIDTH
    // steps the accumulator holds magnitude*magnitude exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_accumulator  <= '0;
        end else if (start) begin
            r_multiplicand <= OUT_WIDTH'(magnitude);
            r_multiplier   <= magnitude;
            r_accumulator  <= '0;
        end else if (step) begin
            if (r_multiplier[0]) begin
                r_accumulator <= r_accumulator + r_multiplicand;
            end
            r_multiplicand <= r_multiplicand << 1;
            r_multiplier   <= r_multiplier >> 1;
        end
    end

    assign square = r_accumulator;

endmodule
`default_nettype wire

// File: rtl/square_sum_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : square_sum_cal                                                   |
// | Brief    : Serial I^2 + Q^2 calculator feeding the square-root stage.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module square_sum_cal
    import square_sum_cal_pkg::*;
#(
    parameter int IN_WIDTH  = C_IN_WIDTH,
    parameter int OUT_WIDTH = C_OUT_WIDTH
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [IN_WIDTH-1:0] iData,
    input  logic signed [IN_WIDTH-1:0] qData,
    output logic [OUT_WIDTH-1:0]       outputData,
    output logic                       dataValid,
    output logic                       busy
);

    localparam int                       c_COUNT_WIDTH = $clog2(IN_WIDTH + 1);
    localparam logic [c_COUNT_WIDTH-1:0] c_LAST_ITER   = c_COUNT_WIDTH'(IN_WIDTH - 1);
    localparam logic [c_COUNT_WIDTH-1:0] c_COUNT_ONE   = c_COUNT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_nextState;
    logic                     w_start;
    logic                     w_step;
    logic [c_COUNT_WIDTH-1:0] r_iterCount;
    logic [IN_WIDTH-1:0]      w_iMag;
    logic [IN_WIDTH-1:0]      w_qMag;
    logic [OUT_WIDTH-1:0]     w_sqI;
    logic [OUT_WIDTH-1:0]     w_sqQ;
    logic [OUT_WIDTH-1:0]     w_sum;
    logic [OUT_WIDTH-1:0]     r_outputData;
    logic                     r_dataValid;
    logic                     r_busy;

    // Negating the most negative value wraps back to 2^(IN_WIDTH-1), which is
    // exactly the right unsigned magnitude.
    always_comb begin
        w_iMag = iData[IN_WIDTH-1] ? -iData : iData;
        w_qMag = qData[IN_WIDTH-1] ? -qData : qData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_start     = 1'b1;
                    w_nextState = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_iterCount == c_LAST_ITER) begin
                    w_nextState = SUM;
                end
            end
            SUM:     w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_iterCount <= '0;
        end else if (w_start) begin
            r_iterCount <= '0;
        end else if (w_step) begin
            r_iterCount <= r_iterCount + c_COUNT_ONE;
        end
    end

    serial_squarer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_squarerI (
        .clock     (clock),
        .reset     (reset),
        .start     (w_start),
        .step      (w_step),
        .magnitude (w_iMag),
        .square    (w_sqI)
    );

    serial_squarer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_squarerQ (
        .clock     (clock),
        .reset     (reset),
        .start     (w_start),
        .step      (w_step),
        .magnitude (w_qMag),
        .square    (w_sqQ)
    );

    // Each square is at most 2^(2*IN_WIDTH-2), so the sum fits without a carry out.
    assign w_sum = w_sqI + w_sqQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outputData <= '0;
            r_dataValid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dataValid <= (r_state == SUM);
            r_busy      <= (w_nextState != IDLE);
            if (r_state == SUM) begin
                r_outputData <= w_sum;
            end
        end
    end

    assign outputData = r_outputData;
    assign dataValid  = r_dataValid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_square_sum_cal.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_square_sum_cal                                                |
// | Brief    : Directed and streamed checks of square_sum_cal.                  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_square_sum_cal;
    import square_sum_cal_pkg::*;

    localparam int IW = C_IN_WIDTH;
    localparam int OW = C_OUT_WIDTH;

    logic                 clock  = 1'b0;
    logic                 reset  = 1'b0;
    logic                 enable = 1'b0;
    logic signed [IW-1:0] iData  = '0;
    logic signed [IW-1:0] qData  = '0;
    logic [OW-1:0]        outputData;
    logic                 dataValid;
    logic                 busy;

    int nChecks = 0;
    int nErrors = 0;
    int cycle   = 0;

    square_sum_cal dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .iData      (iData),
        .qData      (qData),
        .outputData (outputData),
        .dataValid  (dataValid),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] refSq(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b);
        logic signed [OW-1:0] ea;
        logic signed [OW-1:0] eb;
        ea = {{IW{a[IW-1]}}, a};
        eb = {{IW{b[IW-1]}}, b};
        return ea * ea + eb * eb;
    endfunction

    // One operation from an enable pulse; k indexes negedges after the sampling edge.
    task automatic runOp(input string tag, input logic signed [IW-1:0] i, input logic signed [IW-1:0] q,
                         input logic [OW-1:0] exp, input bit disturb, input bit checkBusy);
        logic [OW-1:0] got = '0;
        int busyCnt = 0;
        int vCnt    = 0;
        int vAt     = -1;
        int k       = 0;
        @(negedge clock);
        iData  = i;
        qData  = q;
        enable = 1'b1;
        @(posedge clock);
        do begin
            @(negedge clock);
            if (k == 0) enable = 1'b0;
            if (busy) busyCnt++;
            if (dataValid) begin
                vCnt++;
                vAt = k;
                got = outputData;
            end
            if (disturb) begin
                if (k == 5) begin
                    iData = ~i;
                    qData = i;
                end
                if (k == 10) enable = 1'b1;
                if (k == 11) enable = 1'b0;
                if (k == 72) enable = 1'b1;
            end
            k++;
        end while (busy && k < 300);
        enable = 1'b0;
        check({tag, " pulses"}, OW'(vCnt), OW'(1));
        check({tag, " latency"}, OW'(vAt), OW'(72));
        check({tag, " value"}, got, exp);
        if (checkBusy) check({tag, " busy cycles"}, OW'(busyCnt), OW'(73));
        @(negedge clock);
        check({tag, " no restart"}, OW'(busy), OW'(0));
    endtask

    task automatic streamTest(input int n);
        logic signed [IW-1:0] a;
        logic signed [IW-1:0] b;
        logic [95:0]          r;
        logic [OW-1:0]        exp;
        int k;
        int lastAt = -1;
        @(negedge clock);
        for (int s = 0; s < n; s++) begin
            case (s)
                0: begin a = {1'b1, {(IW-1){1'b0}}}; b = {1'b0, {(IW-1){1'b1}}}; end
                1: begin a = {1'b0, {(IW-1){1'b1}}}; b = {1'b1, {(IW-1){1'b0}}}; end
                2: begin a = '1; b = '0; end
                default: begin
                    r = {$urandom(), $urandom(), $urandom()};
                    a = r[IW-1:0];
                    r = {$urandom(), $urandom(), $urandom()};
                    b = r[IW-1:0];
                end
            endcase
            iData  = a;
            qData  = b;
            enable = 1'b1;
            exp    = refSq(a, b);
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (!dataValid && k < 200);
            check("stream value", outputData, exp);
            if (lastAt >= 0) check("stream period", OW'(cycle - lastAt), OW'(74));
            lastAt = cycle;
            k = 0;
            while (busy && k < 10) begin
                @(negedge clock);
                k++;
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        logic [OW-1:0] e;
        int vCnt;
        int busyCnt;

        repeat (3) @(negedge clock);
        check("reset outputData", outputData, '0);
        check("reset dataValid", OW'(dataValid), OW'(0));
        check("reset busy", OW'(busy), OW'(0));
        reset = 1'b1;
        repeat (2) @(negedge clock);

        runOp("i3q4", 71'sd3, 71'sd4, 142'd25, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        check("hold value", outputData, 142'd25);

        e = 142'd1 << 141;
        runOp("minmin", {1'b1, {(IW-1){1'b0}}}, {1'b1, {(IW-1){1'b0}}}, e, 1'b0, 1'b0);
        e = (142'd1 << 140) - (142'd1 << 71) + 142'd1;
        runOp("max0", {1'b0, {(IW-1){1'b1}}}, 71'sd0, e, 1'b0, 1'b0);
        runOp("zero", 71'sd0, 71'sd0, 142'd0, 1'b0, 1'b1);
        runOp("m1m1", -71'sd1, -71'sd1, 142'd2, 1'b0, 1'b0);
        runOp("1000m7", 71'sd1000, -71'sd7, 142'd1000049, 1'b0, 1'b0);
        runOp("disturb", 71'sd6, -71'sd8, 142'd100, 1'b1, 1'b1);

        streamTest(1000);

        // Abort mid-CALC with asynchronous reset.
        @(negedge clock);
        iData  = 71'sd100;
        qData  = -71'sd3;
        enable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        repeat (29) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async rst outputData", outputData, '0);
        check("async rst dataValid", OW'(dataValid), OW'(0));
        check("async rst busy", OW'(busy), OW'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        vCnt = 0;
        busyCnt = 0;
        repeat (100) begin
            @(negedge clock);
            if (dataValid) vCnt++;
            if (busy) busyCnt++;
        end
        check("abort no pulse", OW'(vCnt), OW'(0));
        check("abort idle", OW'(busyCnt), OW'(0));
        runOp("after rst", -71'sd5, 71'sd12, 142'd169, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_sum_cal.md
SQUARE_SUM_CAL -- requirements
Module: square_sum_cal

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 71, meaning the signed input width of each I and Q sample.
REQ-002 SHALL have parameter OUT_WIDTH, default 142, meaning the unsigned result width, equal to 2*IN_WIDTH.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  start strobe, sampled only in IDLE.
REQ-006 SHALL have port iData  input  IN_WIDTH  signed two's-complement in-phase sample.
REQ-007 SHALL have port qData  input  IN_WIDTH  signed two's-complement quadrature sample.
REQ-008 SHALL have port outputData  output  OUT_WIDTH  unsigned iData^2 + qData^2, in the format expected by the square-root stage.
REQ-009 SHALL have port dataValid  output  1  one-cycle pulse marking a new outputData.
REQ-010 SHALL have port busy  output  1  high while a computation is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, SUM, DONE.
REQ-012 IDLE: enable=1 at an edge SHALL capture |iData| and |qData| as IN_WIDTH-bit unsigned magnitudes, clear the accumulators and iteration counter, and move to CALC.
REQ-013 The magnitude of -2^(IN_WIDTH-1) SHALL be 2^(IN_WIDTH-1) with no overflow.
REQ-014 CALC SHALL run exactly IN_WIDTH cycles, one shift-add iteration per cycle per channel, LSB-first on the multiplier magnitude, with both channels in parallel.
REQ-015 CALC SHALL move to SUM on the edge that completes iteration IN_WIDTH-1.
REQ-016 SUM SHALL register outputData = sqI + sqQ at full OUT_WIDTH precision, set dataValid=1, and move to DONE.
REQ-017 The sum SHALL NOT overflow: the maximum is 2^(OUT_WIDTH-1).
REQ-018 DONE SHALL clear dataValid and move to IDLE on the next edge.
REQ-019 Latency: dataValid SHALL be high exactly during the cycle starting IN_WIDTH+1 edges after the enable-sampling edge (72 for the default).
REQ-020 busy SHALL be registered, rising on the sampling edge and falling on the DONE->IDLE edge; it SHALL equal (state != IDLE).
REQ-021 enable SHALL be ignored in CALC, SUM and DONE: no restart and no queuing.
REQ-022 iData and qData SHALL be ignored outside the sampling edge; changes during CALC SHALL NOT affect the result.
REQ-023 outputData SHALL hold its last value until the next SUM state.
REQ-024 Back-to-back operation: enable held high SHALL start a new operation on the first edge in IDLE, giving a throughput of one result per IN_WIDTH+3 cycles.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, outputData=0, dataValid=0, busy=0, and clear the accumulators, magnitudes and counter.
REQ-026 Reset in any state, including mid-CALC, SHALL abandon the operation with no dataValid pulse.
REQ-027 The first enable after reset release SHALL start normally.

Structure
REQ-028 A shared package SHALL hold IN_WIDTH, OUT_WIDTH, the iteration count, and the FSM state encoding; the square-root stage SHALL use the same width constants.
REQ-029 A single sub-module serial_squarer (magnitude in, shift-add square accumulator out, driven by a start and step control from the parent) SHALL be instantiated twice, for I and Q.
REQ-030 The parent SHALL own the FSM, the counter, the final adder and the output registers.

Verification
REQ-031 iData=3, qData=4, enable pulse -> after 72 cycles dataValid=1 for one cycle, outputData=25, busy high for 73 cycles.
REQ-032 iData=-2^70, qData=-2^70 -> outputData=2^141 with no overflow; iData=2^70-1, qData=0 -> outputData=(2^70-1)^2.
REQ-033 iData=0, qData=0 -> outputData=0, and dataValid still pulses at cycle 72.
REQ-034 enable re-pulsed at cycles 10 and 72, with iData/qData changed mid-CALC -> a single result for the original inputs; enable held high continuously -> results every 74 cycles.
REQ-035 reset asserted at cycle 30 of CALC -> all outputs 0 immediately, no dataValid pulse; after release, iData=-5, qData=12 -> outputData=169.
REQ-036 Random signed I/Q (>=1000 samples, including extremes) -> outputData matches the reference model I*I+Q*Q bit-exact.
